decode_rename_fifo: RTL and testbench

Multi-port circular FIFO between the decode stage and the rename stage. Accepts up to IN_PORTS decoded `decode_rename_pack_t` entries per cycle from decode, presents the oldest OUT_PORTS entries to rename, and retires a variable-length in-order prefix per cycle. Advertises free capacity per lane back to decode, reports full/empty status to the CSR performance counters, and is cleared in one cycle by a commit-driven flush.

---
 rtl/decode_rename_fifo.sv | 113 +++++++++++
 tb/tb_decode_rename_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_rename_fifo.sv
// Multi-port circular FIFO between decode and rename: up to IN_PORTS pushes and
// an in-order prefix of up to OUT_PORTS pops per cycle, with one-cycle flush.
package decode_rename_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } decode_rename_pack_t;
endpackage

module decode_rename_fifo
  import decode_rename_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned IN_PORTS  = 3,
  parameter int unsigned OUT_PORTS = 3
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  decode_rename_pack_t [0:IN_PORTS-1]      data_in,
  input  logic [IN_PORTS-1:0]                     data_in_valid,
  input  logic                                    push,
  output logic [IN_PORTS-1:0]                     data_in_enable,
  output decode_rename_pack_t [0:OUT_PORTS-1]     data_out,
  output logic [OUT_PORTS-1:0]                    data_out_valid,
  input  logic [OUT_PORTS-1:0]                    data_pop_valid,
  input  logic                                    pop,
  input  logic                                    flush,
  output logic                                    full,
  output logic                                    empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  decode_rename_pack_t storage [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] free;
  logic [CNT_W-1:0] n_push;
  logic [CNT_W-1:0] n_pop;
  logic [IN_PORTS-1:0] accept;
  logic [PTR_W-1:0] offset [IN_PORTS];

  assign free  = CNT_W'(DEPTH) - count;
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Lane status depends only on registered occupancy.
  for (genvar g = 0; g < IN_PORTS; g++) begin : g_in_en
    assign data_in_enable[g] = (free > CNT_W'(g));
  end

  for (genvar g = 0; g < OUT_PORTS; g++) begin : g_out_vld
    assign data_out_valid[g] = (count > CNT_W'(g));
  end

  always_comb begin
    data_out = '0;
    for (int unsigned i = 0; i < OUT_PORTS; i++) begin
      if (data_out_valid[i]) data_out[i] = storage[rptr + PTR_W'(i)];
    end
  end

  // Accepted lanes are compacted onto consecutive slots from wptr.
  always_comb begin
    accept = '0;
    n_push = '0;
    for (int unsigned i = 0; i < IN_PORTS; i++) begin
      offset[i] = PTR_W'(n_push);
      if (push && data_in_valid[i] && data_in_enable[i] && !flush) begin
        accept[i] = 1'b1;
        n_push    = n_push + CNT_W'(1);
      end
    end
  end

  // Only the contiguous retired prefix from lane 0 advances the read pointer.
  always_comb begin
    logic run;
    run   = 1'b1;
    n_pop = '0;
    for (int unsigned i = 0; i < OUT_PORTS; i++) begin
      if (run && pop && data_pop_valid[i] && data_out_valid[i] && !flush) begin
        n_pop = n_pop + CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      rptr  <= rptr + PTR_W'(n_pop);
      wptr  <= wptr + PTR_W'(n_push);
      count <= count + n_push - n_pop;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < IN_PORTS; i++) begin
      if (rst && accept[i]) storage[wptr + offset[i]] <= data_in[i];
    end
  end

endmodule

// File: tb/tb_decode_rename_fifo.sv
// Directed bench for decode_rename_fifo: a queue model checked every cycle plus
// hand-computed expectations at the interesting points.
module tb_decode_rename_fifo;
  import decode_rename_pkg::*;

  localparam int DEPTH = 16;
  localparam int IN_P  = 3;
  localparam int OUT_P = 3;

  logic clk = 1'b0;
  logic rst;
  decode_rename_pack_t [0:IN_P-1]  data_in;
  logic [IN_P-1:0]                 data_in_valid;
  logic                            push;
  logic [IN_P-1:0]                 data_in_enable;
  decode_rename_pack_t [0:OUT_P-1] data_out;
  logic [OUT_P-1:0]                data_out_valid;
  logic [OUT_P-1:0]                data_pop_valid;
  logic                            pop;
  logic                            flush;
  logic                            full;
  logic                            empty;

  decode_rename_fifo #(.DEPTH(DEPTH), .IN_PORTS(IN_P), .OUT_PORTS(OUT_P)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .push(push), .data_in_enable(data_in_enable), .data_out(data_out),
    .data_out_valid(data_out_valid), .data_pop_valid(data_pop_valid), .pop(pop),
    .flush(flush), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic decode_rename_pack_t mk(logic [31:0] pc);
    decode_rename_pack_t e;
    e.pc   = pc;
    e.inst = pc ^ 32'hdead_beef;
    e.rd   = pc[6:2];
    e.rs1  = pc[11:7];
    e.rs2  = pc[4:0];
    return e;
  endfunction

  // Reference: FIFO contents as a queue; capacity from pre-update occupancy.
  decode_rename_pack_t mq [$];
  decode_rename_pack_t nq [$];
  int nfree, np;
  logic go;

  always @(posedge clk) begin
    if (!rst || flush) begin
      mq.delete();
    end else begin
      nfree = DEPTH - mq.size();
      nq.delete();
      for (int i = 0; i < IN_P; i++)
        if (push && data_in_valid[i] && i < nfree) nq.push_back(data_in[i]);
      np = 0;
      go = 1'b1;
      for (int i = 0; i < OUT_P; i++) begin
        if (go && pop && data_pop_valid[i] && i < mq.size()) np++;
        else go = 1'b0;
      end
      repeat (np) void'(mq.pop_front());
      foreach (nq[k]) mq.push_back(nq[k]);
    end
  end

  logic ev;
  decode_rename_pack_t ed;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < OUT_P; i++) begin
        ev = (i < mq.size());
        ed = ev ? mq[i] : '0;
        chk($sformatf("model_valid%0d", i), 128'(data_out_valid[i]), 128'(ev));
        chk($sformatf("model_data%0d", i), 128'(data_out[i]), 128'(ed));
      end
      for (int i = 0; i < IN_P; i++)
        chk($sformatf("model_enable%0d", i), 128'(data_in_enable[i]),
            128'(i < DEPTH - mq.size()));
      chk("model_full", 128'(full), 128'(mq.size() == DEPTH));
      chk("model_empty", 128'(empty), 128'(mq.size() == 0));
    end
  end

  task automatic step(input logic p, input logic [2:0] vin, input logic [31:0] pc0,
                      input logic [31:0] pc1, input logic [31:0] pc2, input logic po,
                      input logic [2:0] pv, input logic fl);
    push = p;
    data_in_valid = vin;
    data_in[0] = mk(pc0);
    data_in[1] = mk(pc1);
    data_in[2] = mk(pc2);
    pop = po;
    data_pop_valid = pv;
    flush = fl;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 3'b000, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    push = 1'b0; pop = 1'b0; flush = 1'b0;
    data_in_valid = '0; data_pop_valid = '0; data_in = '0;
    @(negedge clk);
    chk_en = 1'b1;
    idle();
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_enable", 128'(data_in_enable), 128'(3'b111));
    chk("rst_valid", 128'(data_out_valid), 128'(3'b000));
    chk("rst_data", 128'(data_out), 128'(0));
    rst = 1'b1;

    // First push of three lanes
    step(1'b1, 3'b111, 32'h100, 32'h104, 32'h108, 1'b0, 3'b000, 1'b0);
    chk("p1_valid", 128'(data_out_valid), 128'(3'b111));
    chk("p1_pc0", 128'(data_out[0].pc), 128'(32'h100));
    chk("p1_pc1", 128'(data_out[1].pc), 128'(32'h104));
    chk("p1_pc2", 128'(data_out[2].pc), 128'(32'h108));
    chk("p1_empty", 128'(empty), 128'(0));

    // Fill to saturation
    for (int k = 1; k < 6; k++) begin
      step(1'b1, 3'b111, 32'h100 + 12 * k, 32'h104 + 12 * k, 32'h108 + 12 * k,
           1'b0, 3'b000, 1'b0);
      if (k == 4) chk("fill15_enable", 128'(data_in_enable), 128'(3'b001));
    end
    chk("fill_full", 128'(full), 128'(1));
    chk("fill_enable", 128'(data_in_enable), 128'(3'b000));
    step(1'b1, 3'b111, 32'h900, 32'h904, 32'h908, 1'b0, 3'b000, 1'b0);
    chk("full_noop_pc0", 128'(data_out[0].pc), 128'(32'h100));
    chk("full_noop_full", 128'(full), 128'(1));

    // Down to 15, then push 3 / pop 2 together
    step(1'b0, 3'b000, 0, 0, 0, 1'b1, 3'b001, 1'b0);
    chk("c15_pc0", 128'(data_out[0].pc), 128'(32'h104));
    step(1'b1, 3'b111, 32'ha00, 32'ha04, 32'ha08, 1'b1, 3'b011, 1'b0);
    chk("pp_pc0", 128'(data_out[0].pc), 128'(32'h10c));
    chk("pp_enable", 128'(data_in_enable), 128'(3'b011));
    chk("pp_full", 128'(full), 128'(0));

    // Gapped pop retires only lane 0
    step(1'b0, 3'b000, 0, 0, 0, 1'b1, 3'b101, 1'b0);
    chk("gap_pop_pc0", 128'(data_out[0].pc), 128'(32'h110));
    step(1'b0, 3'b000, 0, 0, 0, 1'b1, 3'b111, 1'b0);
    chk("c10_pc0", 128'(data_out[0].pc), 128'(32'h11c));

    // Flush beats push and pop at count 10
    step(1'b1, 3'b111, 32'hb00, 32'hb04, 32'hb08, 1'b1, 3'b111, 1'b1);
    chk("fl_empty", 128'(empty), 128'(1));
    chk("fl_enable", 128'(data_in_enable), 128'(3'b111));
    chk("fl_valid", 128'(data_out_valid), 128'(3'b000));
    step(1'b1, 3'b001, 32'h500, 0, 0, 1'b0, 3'b000, 1'b0);
    chk("post_fl_pc0", 128'(data_out[0].pc), 128'(32'h500));
    chk("post_fl_valid", 128'(data_out_valid), 128'(3'b001));

    // Walk pointers to 14, then push across the wrap
    step(1'b0, 3'b000, 0, 0, 0, 1'b1, 3'b111, 1'b0);
    chk("pop_empty_ok", 128'(empty), 128'(1));
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 3'b111, 32'h600 + 16 * k, 32'h604 + 16 * k, 32'h608 + 16 * k,
           1'b0, 3'b000, 1'b0);
      step(1'b0, 3'b000, 0, 0, 0, 1'b1, 3'b111, 1'b0);
    end
    step(1'b1, 3'b001, 32'h6f0, 0, 0, 1'b0, 3'b000, 1'b0);
    step(1'b0, 3'b000, 0, 0, 0, 1'b1, 3'b111, 1'b0);
    step(1'b1, 3'b111, 32'h700, 32'h704, 32'h708, 1'b0, 3'b000, 1'b0);
    chk("wrap_pc0", 128'(data_out[0].pc), 128'(32'h700));
    chk("wrap_pc1", 128'(data_out[1].pc), 128'(32'h704));
    chk("wrap_pc2", 128'(data_out[2].pc), 128'(32'h708));
    chk("wrap_inst2", 128'(data_out[2].inst), 128'(32'h708 ^ 32'hdead_beef));

    // Gapped push is compacted
    step(1'b0, 3'b000, 0, 0, 0, 1'b1, 3'b111, 1'b0);
    step(1'b1, 3'b101, 32'h800, 32'h804, 32'h808, 1'b0, 3'b000, 1'b0);
    chk("cmp_valid", 128'(data_out_valid), 128'(3'b011));
    chk("cmp_pc0", 128'(data_out[0].pc), 128'(32'h800));
    chk("cmp_pc1", 128'(data_out[1].pc), 128'(32'h808));

    // Reset mid-burst discards content and ignores inputs
    rst = 1'b0;
    step(1'b1, 3'b111, 32'hc00, 32'hc04, 32'hc08, 1'b1, 3'b111, 1'b0);
    chk("rst_mid_empty", 128'(empty), 128'(1));
    chk("rst_mid_valid", 128'(data_out_valid), 128'(3'b000));
    rst = 1'b1;
    step(1'b1, 3'b011, 32'hd00, 32'hd04, 0, 1'b0, 3'b000, 1'b0);
    chk("after_rst_pc1", 128'(data_out[1].pc), 128'(32'hd04));
    idle();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
